// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter slice: datapath width,
// arbiter FSM state type and requester-id type.
package addsub_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One bit selects between the two requesters.
    typedef logic req_id_t;

endpackage

// File: rtl/add_sub_8bit.sv
// Shared 8-bit add/subtract datapath. Wraps modulo 2^8; no carry out.
module add_sub_8bit
    import addsub_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Subtract,
    output logic [DATA_W-1:0] Result
);

    assign Result = Subtract ? (A - B) : (A + B);

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of one shared add/sub datapath.
// IDLE accepts one operation, EXEC registers the datapath result,
// RESP holds it until the consumer takes it.
// Build option: define ADDSUB_ARB_RR_EN for round-robin contention
// handling; otherwise requester 0 has fixed priority.
module addsub_arbiter
    import addsub_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_A,
    input  logic [DATA_W-1:0] req0_B,
    input  logic              req0_Subtract,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_A,
    input  logic [DATA_W-1:0] req1_B,
    input  logic              req1_Subtract,
    output logic              resp_valid,
    input  logic              resp_ready,
    output req_id_t           resp_id,
    output logic [DATA_W-1:0] Result
);

    state_t            state;
    req_id_t           grant;
    req_id_t           id_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              sub_q;
    logic [DATA_W-1:0] dp_result;
    logic              any_valid;

    assign any_valid = req0_valid | req1_valid;

`ifdef ADDSUB_ARB_RR_EN
    req_id_t last_grant;

    // Remember who won the most recent acceptance; reset favours requester 0.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (state == IDLE && any_valid)
            last_grant <= grant;
    end
`endif

    // Pick the winner among pending requesters.
    always_comb begin
        grant = 1'b0;
        if (req1_valid && !req0_valid)
            grant = 1'b1;
        else if (req0_valid && req1_valid) begin
`ifdef ADDSUB_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end
    end

    // Ready only for the winner, and only while waiting for work.
    assign req0_ready = (state == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = (state == IDLE) && req1_valid && (grant == 1'b1);

    add_sub_8bit u_add_sub (
        .A        (a_q),
        .B        (b_q),
        .Subtract (sub_q),
        .Result   (dp_result)
    );

    // Accept -> execute -> respond; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            Result     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_q   <= grant ? req1_A : req0_A;
                        b_q   <= grant ? req1_B : req0_B;
                        sub_q <= grant ? req1_Subtract : req0_Subtract;
                        id_q  <= grant;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    Result     <= dp_result;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with an operation-level reference model.
module tb_addsub_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_A, req0_B, req1_A, req1_B;
    logic       req0_Subtract, req1_Subtract;
    logic       resp_valid, resp_ready;
    logic       resp_id;
    logic [7:0] Result;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    int log_id[$];
    int log_res[$];

    addsub_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_A        (req0_A),
        .req0_B        (req0_B),
        .req0_Subtract (req0_Subtract),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_A        (req1_A),
        .req1_B        (req1_B),
        .req1_Subtract (req1_Subtract),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .Result        (Result)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, result appears two cycles
    // after the acceptance cycle and stays until the consumer takes it.
    bit m_busy, m_left, m_valid;
    int m_res, m_id, p_res, p_id;
    int m_last;

    function automatic int m_grant();
        if (req0_valid && !req1_valid) return 0;
        if (req1_valid && !req0_valid) return 1;
`ifdef ADDSUB_ARB_RR_EN
        return 1 - m_last;
`else
        return 0;
`endif
    endfunction

    function automatic int arith(input int a, input int b, input int s);
        if (s != 0) return (a - b + 256) % 256;
        return (a + b) % 256;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_left <= 0; m_valid <= 0;
            m_res <= 0; m_id <= 0; m_last <= 1;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                if (m_grant() == 0)
                    p_res <= arith(req0_A, req0_B, req0_Subtract);
                else
                    p_res <= arith(req1_A, req1_B, req1_Subtract);
                p_id   <= m_grant();
                m_last <= m_grant();
                m_busy <= 1;
                m_left <= 1;
            end
        end else if (m_left) begin
            m_left  <= 0;
            m_valid <= 1;
            m_res   <= p_res;
            m_id    <= p_id;
        end else if (resp_ready) begin
            m_valid <= 0;
            m_busy  <= 0;
        end
    end

    // Every-cycle comparison against the model, plus response logging.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req0_ready", int'(req0_ready), int'(!m_busy && req0_valid && m_grant() == 0));
            check("req1_ready", int'(req1_ready), int'(!m_busy && req1_valid && m_grant() == 1));
            check("resp_valid", int'(resp_valid), int'(m_valid));
            check("Result", int'(Result), m_res);
            check("resp_id", int'(resp_id), m_id);
            if (resp_valid && resp_ready) begin
                log_id.push_back(int'(resp_id));
                log_res.push_back(int'(Result));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input int a, input int b, input int s);
        if (r == 0) begin
            req0_valid = v; req0_A = 8'(a); req0_B = 8'(b); req0_Subtract = s[0];
        end else begin
            req1_valid = v; req1_A = 8'(a); req1_B = 8'(b); req1_Subtract = s[0];
        end
    endtask

    // Issue one op from an idle DUT; returns at the negedge where resp_valid is seen.
    task automatic run_op(input int r, input int a, input int b, input int s, output int lat);
        set_req(r, 1, a, b, s);
        @(negedge clk);
        check("accept_ready", int'(r == 0 ? req0_ready : req1_ready), 1);
        tick();
        set_req(r, 0, 0, 0, 0);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_resp();
        tick();
        @(negedge clk);
        check("resp_drop", int'(resp_valid), 0);
        tick();
    endtask

    int lat;
    int exp_ids[4];

    initial begin
        reset = 1; resp_ready = 1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        tick(); tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_Result", int'(Result), 0);
        check("rst_resp_id", int'(resp_id), 0);
        tick();
        reset = 0;
        tick();

        // 11 + 15 from requester 0
        run_op(0, 11, 15, 0, lat);
        check("op1_latency", lat, 2);
        check("op1_Result", int'(Result), 26);
        check("op1_id", int'(resp_id), 0);
        finish_resp();

        // requester 1 ops, including wrap-around in both directions
        run_op(1, 50, 10, 1, lat);
        check("op2_latency", lat, 2);
        check("op2_Result", int'(Result), 40);
        check("op2_id", int'(resp_id), 1);
        finish_resp();
        run_op(1, 10, 20, 1, lat);
        check("op3_Result", int'(Result), 246);
        check("op3_id", int'(resp_id), 1);
        finish_resp();
        run_op(1, 200, 100, 0, lat);
        check("op4_Result", int'(Result), 44);
        finish_resp();

        // contention: both valid for four back-to-back ops
        reset = 1;
        tick();
        reset = 0;
        log_id.delete(); log_res.delete();
        set_req(0, 1, 1, 2, 0);
        set_req(1, 1, 9, 4, 1);
        repeat (10) tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        for (int k = 0; k < 30 && log_id.size() < 4; k++) @(negedge clk);
        check("contend_count", log_id.size(), 4);
`ifdef ADDSUB_ARB_RR_EN
        exp_ids = '{0, 1, 0, 1};
`else
        exp_ids = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4 && i < log_id.size(); i++) begin
            check($sformatf("contend_id%0d", i), log_id[i], exp_ids[i]);
            check($sformatf("contend_res%0d", i), log_res[i], exp_ids[i] == 0 ? 3 : 5);
        end
        tick();

        // consumer stalls: response must hold, requesters must be ignored
        resp_ready = 0;
        run_op(0, 7, 3, 1, lat);
        check("stall_latency", lat, 2);
        tick();
        set_req(0, 1, 100, 1, 0);
        set_req(1, 1, 100, 2, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", int'(resp_valid), 1);
            check("stall_Result", int'(Result), 4);
            check("stall_id", int'(resp_id), 0);
            check("stall_r0", int'(req0_ready), 0);
            check("stall_r1", int'(req1_ready), 0);
        end
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        resp_ready = 1;
        finish_resp();

        // reset while executing drops the op
        log_id.delete(); log_res.delete();
        set_req(0, 1, 5, 5, 0);
        @(negedge clk);
        check("drop_accept", int'(req0_ready), 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("drop_valid", int'(resp_valid), 0);
        check("drop_Result", int'(Result), 0);
        check("drop_r0_idle", int'(req0_ready), 0);
        repeat (6) @(negedge clk);
        check("drop_no_resp", log_id.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameters: none; data width SHALL be the 8-bit width fixed by the shared add/sub datapath.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_A, req0_B  input  8 each  requester 0 operands.
REQ-007 req0_Subtract  input  1  requester 0 op select: 1 = A-B, 0 = A+B.
REQ-008 req1_valid, req1_ready, req1_A, req1_B, req1_Subtract  SHALL have the same directions, widths and meanings for requester 1.
REQ-009 resp_valid  output  1  Result/resp_id valid.
REQ-010 resp_ready  input  1  consumer accepts response.
REQ-011 resp_id  output  1  index of the requester that owns Result.
REQ-012 Result  output  8  registered datapath result.

Function
REQ-013 FSM SHALL have states IDLE, EXEC and RESP.
REQ-014 IDLE: reqN_ready SHALL be high, combinationally, only for the granted requester, and only when its reqN_valid is high; all other ready outputs SHALL be low.
REQ-015 Acceptance (valid and ready both high) in IDLE SHALL latch A, B, Subtract and the grant index, and SHALL move the FSM to EXEC.
REQ-016 EXEC: latched operands SHALL drive the single add/sub instance; its Result SHALL be registered, and the FSM SHALL move to RESP on the next edge.
REQ-017 resp_valid SHALL rise exactly 2 cycles after the acceptance edge.
REQ-018 RESP: resp_valid high; Result and resp_id SHALL hold stable until the cycle in which resp_ready is high.
REQ-019 RESP with resp_ready high: FSM SHALL return to IDLE on that edge, and resp_valid SHALL be low in the following cycle.
REQ-020 In EXEC and RESP, both reqN_ready outputs SHALL be low; requester inputs SHALL be ignored.
REQ-021 Arithmetic SHALL be modulo 2^8 with no carry or overflow output.
REQ-022 Only one requester valid: that requester SHALL be granted.
REQ-023 Both requesters valid: the grant SHALL follow REQ-030/REQ-031.
REQ-024 No requester valid: FSM SHALL stay in IDLE.
REQ-025 Minimum throughput SHALL be one operation per 3 cycles; back-to-back acceptance SHALL occur no sooner than the cycle after the response handshake.

Reset
REQ-026 On reset the FSM SHALL enter IDLE.
REQ-027 On reset resp_valid SHALL be 0, Result SHALL be 8'h00 and resp_id SHALL be 0.
REQ-028 On reset the last-grant register SHALL be 1, so requester 0 wins the first contention.
REQ-029 Reset asserted in EXEC or RESP SHALL discard the operation; no response SHALL be issued for it.

Configuration
REQ-030 With macro ADDSUB_ARB_RR_EN defined, contention SHALL be resolved round-robin: the requester not granted last SHALL win, and the last-grant register SHALL update on each acceptance.
REQ-031 Without ADDSUB_ARB_RR_EN, fixed priority SHALL apply: requester 0 SHALL always win contention, and the last-grant register SHALL be absent.

Structure
REQ-032 Shared package addsub_pkg SHALL hold localparam DATA_W = 8, the FSM state enum type (IDLE/EXEC/RESP) and the requester-id typedef.
REQ-033 The existing add_sub_8bit module SHALL be instantiated once as the sole sub-module; no other arithmetic SHALL be inferred.

Verification
REQ-034 req0 A=11, B=15, Subtract=0, resp_ready=1 -> Result=26, resp_id=0, resp_valid exactly 2 cycles after accept, high for 1 cycle.
REQ-035 req1 A=50, B=10, Subtract=1 -> Result=40, resp_id=1; also A=10, B=20, Subtract=1 -> Result=246, and A=200, B=100, Subtract=0 -> Result=44.
REQ-036 Both valid continuously for 4 ops -> with ADDSUB_ARB_RR_EN, resp_id sequence 0,1,0,1; without it, 0,0,0,0.
REQ-037 resp_ready held low 3 cycles in RESP -> Result, resp_id and resp_valid stable; req0_ready = req1_ready = 0 throughout.
REQ-038 Reset pulsed 1 cycle while in EXEC -> next cycle resp_valid=0, Result=0, FSM IDLE; no response for the dropped op.
